// File: rtl/seq_booth_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient bit per clock,
// followed by a sign-fix cycle that publishes registered results and a one-cycle done pulse.
module seq_booth_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Iteration datapath
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   prem_q, prem_d;
   logic [WIDTH-1:0] qsh_q, qsh_d;
   logic [WIDTH-1:0] dsr_mag_q, dsr_mag_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic             sign_q_q, sign_q_d;
   logic             sign_r_q, sign_r_d;
   logic             dbz_pend_q, dbz_pend_d;
   logic             ovf_pend_q, ovf_pend_d;

   // Published results
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] dvd_mag, dsr_mag;
   logic [WIDTH+1:0] rem_wide;
   logic [WIDTH:0]   trial_diff;
   logic             trial_ge;
   logic             last_iter;

   // Magnitudes as unsigned values; the most negative operand maps onto 2^(WIDTH-1).
   assign dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
   assign dsr_mag = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;

   assign rem_wide   = {prem_q, qsh_q[WIDTH-1]};
   assign trial_ge   = (rem_wide >= {2'b00, dsr_mag_q});
   assign trial_diff = rem_wide[WIDTH:0] - {1'b0, dsr_mag_q};
   assign last_iter  = (cnt_q == CW'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_CALC;
         S_CALC:  if (last_iter) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q != S_IDLE);
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;
      if (state_q == S_FIX) begin
         done_d = 1'b1;
         if (dbz_pend_q) begin
            quotient_d  = '1;
            remainder_d = dvd_q;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
         end else if (ovf_pend_q) begin
            quotient_d  = {1'b1, {(WIDTH-1){1'b0}}};
            remainder_d = '0;
            dbz_d       = 1'b0;
            ovf_d       = 1'b1;
         end else begin
            quotient_d  = sign_q_q ? (~qsh_q + 1'b1) : qsh_q;
            remainder_d = sign_r_q ? (~prem_q[WIDTH-1:0] + 1'b1) : prem_q[WIDTH-1:0];
            dbz_d       = 1'b0;
            ovf_d       = 1'b0;
         end
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      prem_d     = prem_q;
      qsh_d      = qsh_q;
      dsr_mag_d  = dsr_mag_q;
      dvd_d      = dvd_q;
      sign_q_d   = sign_q_q;
      sign_r_d   = sign_r_q;
      dbz_pend_d = dbz_pend_q;
      ovf_pend_d = ovf_pend_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d      = '0;
               prem_d     = '0;
               qsh_d      = dvd_mag;
               dsr_mag_d  = dsr_mag;
               dvd_d      = dividend;
               sign_q_d   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               sign_r_d   = dividend[WIDTH-1];
               dbz_pend_d = (divisor == '0);
               ovf_pend_d = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
            end
         end
         S_CALC: begin
            // Shift in the next dividend bit, keep the trial difference only when it is non-negative.
            prem_d = trial_ge ? trial_diff : rem_wide[WIDTH:0];
            qsh_d  = {qsh_q[WIDTH-2:0], trial_ge};
            cnt_d  = cnt_q + 1'b1;
         end
         default: ;
      endcase
   end

   // Every register, datapath included, is cleared by reset so an abandoned operation leaves no trace.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         prem_q      <= '0;
         qsh_q       <= '0;
         dsr_mag_q   <= '0;
         dvd_q       <= '0;
         sign_q_q    <= 1'b0;
         sign_r_q    <= 1'b0;
         dbz_pend_q  <= 1'b0;
         ovf_pend_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         prem_q      <= prem_d;
         qsh_q       <= qsh_d;
         dsr_mag_q   <= dsr_mag_d;
         dvd_q       <= dvd_d;
         sign_q_q    <= sign_q_d;
         sign_r_q    <= sign_r_d;
         dbz_pend_q  <= dbz_pend_d;
         ovf_pend_q  <= ovf_pend_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
         done_q      <= done_d;
      end
   end

   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_booth_divider.sv
// Bench for seq_booth_divider: directed table, handshake/reset sequences, exhaustive and random sweeps
// against a truncating-division reference model.
module tb_seq_booth_divider;

   localparam int W   = 4;
   localparam int LAT = W + 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic         overflow;

   int n_vec = 0;
   int n_err = 0;

   seq_booth_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           a;
      int           b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ov;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: truncating signed division with the two special cases.
   function automatic vec_t model(input int a, input int b);
      vec_t v;
      int   qi;
      int   ri;
      int   amin;
      amin = -(1 << (W - 1));
      v.a  = a;
      v.b  = b;
      v.dz = 1'b0;
      v.ov = 1'b0;
      if (b == 0) begin
         qi   = -1;
         ri   = a;
         v.dz = 1'b1;
      end else if (a == amin && b == -1) begin
         qi   = amin;
         ri   = 0;
         v.ov = 1'b1;
      end else begin
         qi = a / b;
         ri = a % b;
      end
      v.q = qi[W-1:0];
      v.r = ri[W-1:0];
      return v;
   endfunction

   // Counts rising edges until done is seen; caller sits 1 time unit after an edge.
   task automatic wait_done(output int lat, output bit got);
      lat = 0;
      got = 0;
      while (!got && lat < 4 * W) begin
         @(posedge clk);
         lat++;
         #1;
         if (done) got = 1;
      end
      if (!got) check("done_timeout", 0, 1);
   endtask

   task automatic check_result(input string tag, input vec_t e, input int lat);
      check({tag, "_q"},   32'(quotient),    32'(e.q));
      check({tag, "_r"},   32'(remainder),   32'(e.r));
      check({tag, "_dz"},  32'(div_by_zero), 32'(e.dz));
      check({tag, "_ov"},  32'(overflow),    32'(e.ov));
      check({tag, "_lat"}, 32'(lat),         32'(LAT));
      check({tag, "_busy_with_done"}, 32'(busy), 32'd0);
   endtask

   task automatic do_op(input int a, input int b, input string tag);
      int lat;
      bit got;
      vec_t e;
      start    = 1'b1;
      dividend = a[W-1:0];
      divisor  = b[W-1:0];
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(lat, got);
      e = model(a, b);
      check_result(tag, e, lat);
      // Results must hold and done must drop after the pulse.
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold"}, 32'(quotient), 32'(e.q));
   endtask

   vec_t tbl[12];

   initial begin
      int   lat;
      bit   got;
      bit   seen;
      int   ra;
      int   rb;
      vec_t e;
      int   ops_a[5];
      int   ops_b[5];

      tbl[0]  = '{7,  2,  4'h3, 4'h1, 1'b0, 1'b0};
      tbl[1]  = '{-7, 2,  4'hD, 4'hF, 1'b0, 1'b0};
      tbl[2]  = '{7,  -2, 4'hD, 4'h1, 1'b0, 1'b0};
      tbl[3]  = '{-8, 3,  4'hE, 4'hE, 1'b0, 1'b0};
      tbl[4]  = '{5,  0,  4'hF, 4'h5, 1'b1, 1'b0};
      tbl[5]  = '{-8, -1, 4'h8, 4'h0, 1'b0, 1'b1};
      tbl[6]  = '{6,  3,  4'h2, 4'h0, 1'b0, 1'b0};
      tbl[7]  = '{0,  5,  4'h0, 4'h0, 1'b0, 1'b0};
      tbl[8]  = '{7,  7,  4'h1, 4'h0, 1'b0, 1'b0};
      tbl[9]  = '{-1, 7,  4'h0, 4'hF, 1'b0, 1'b0};
      tbl[10] = '{-8, 1,  4'h8, 4'h0, 1'b0, 1'b0};
      tbl[11] = '{3,  -8, 4'h0, 4'h3, 1'b0, 1'b0};

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_q",    32'(quotient), 32'd0);
      check("rst_r",    32'(remainder), 32'd0);
      check("rst_dz",   32'(div_by_zero), 32'd0);
      check("rst_ov",   32'(overflow), 32'd0);
      rst_n = 1'b1;

      // Directed table with hand-derived expectations.
      for (int i = 0; i < 12; i++) begin
         start    = 1'b1;
         dividend = tbl[i].a[W-1:0];
         divisor  = tbl[i].b[W-1:0];
         @(posedge clk);
         #1;
         start = 1'b0;
         wait_done(lat, got);
         check_result($sformatf("tbl%0d", i), tbl[i], lat);
      end

      // Start pulse two edges into an operation is ignored.
      start    = 1'b1;
      dividend = 4'd7;
      divisor  = 4'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = 4'hA;
      divisor  = 4'h3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, got);
      check_result("ignored_start", tbl[0], lat + 2);
      seen = 0;
      repeat (2 * LAT) begin
         @(posedge clk);
         #1;
         if (done) seen = 1;
      end
      check("ignored_start_no_second_done", 32'(seen), 32'd0);

      // Start held high: each accept takes place in the done cycle of the previous result.
      for (int i = 0; i < 5; i++) begin
         ops_a[i] = $urandom_range(15) - 8;
         ops_b[i] = $urandom_range(15) - 8;
      end
      start    = 1'b1;
      dividend = ops_a[0][W-1:0];
      divisor  = ops_b[0][W-1:0];
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (i < 4) begin
            dividend = ops_a[i+1][W-1:0];
            divisor  = ops_b[i+1][W-1:0];
         end else begin
            start = 1'b0;
         end
         wait_done(lat, got);
         e = model(ops_a[i], ops_b[i]);
         check_result($sformatf("b2b%0d", i), e, lat);
      end
      @(posedge clk);
      #1;

      // Reset three edges into an operation abandons it.
      start    = 1'b1;
      dividend = 4'd7;
      divisor  = 4'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_q",    32'(quotient), 32'd0);
      check("midrst_r",    32'(remainder), 32'd0);
      check("midrst_dz",   32'(div_by_zero), 32'd0);
      check("midrst_ov",   32'(overflow), 32'd0);
      seen = 0;
      repeat (3 * LAT) begin
         @(posedge clk);
         #1;
         if (done || busy) seen = 1;
      end
      check("midrst_quiet", 32'(seen), 32'd0);
      do_op(6, 3, "after_rst");

      // Exhaustive sweep against the model.
      for (int a = -8; a < 8; a++) begin
         for (int b = -8; b < 8; b++) begin
            start    = 1'b1;
            dividend = a[W-1:0];
            divisor  = b[W-1:0];
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_done(lat, got);
            e = model(a, b);
            check_result($sformatf("sweep_%0d_%0d", a, b), e, lat);
         end
      end

      // Randomised operations with idle gaps.
      for (int i = 0; i < 60; i++) begin
         ra = $urandom_range(15) - 8;
         rb = $urandom_range(15) - 8;
         repeat ($urandom_range(2)) @(posedge clk);
         #1;
         do_op(ra, rb, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
